// File: rtl/mn_cycle_tick_scheduler.sv
// Avalon-MM master for the 1 ms interval timer: arms and verifies the timeout IRQ,
// acknowledges each tick and divides ticks into POWERLINK MN cycles.
module mn_cycle_tick_scheduler #(
  parameter int TICK_W     = 8,
  parameter int CNT_W      = 16,
  parameter int MUX_CYCLES = 4,
  parameter int MUX_W      = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [TICK_W-1:0] cycle_len,
  output logic [2:0]        tmr_address,
  output logic              tmr_chipselect,
  output logic              tmr_write_n,
  output logic [15:0]       tmr_writedata,
  input  logic [15:0]       tmr_readdata,
  input  logic              tmr_irq,
  output logic              cycle_start,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [MUX_W-1:0]  mux_slot,
  output logic              cfg_error,
  output logic              busy
);

  typedef enum logic [3:0] {
    IDLE, CFG, VRD, VCHK, CLR, WAIT, ACK, SETTLE, DIS
  } state_t;

  state_t            state, state_nxt;
  logic [TICK_W-1:0] tick_cnt;
  logic [TICK_W-1:0] len_q;
  logic [TICK_W-1:0] len_m1;
  logic              boundary;
  logic              unused_rd;

  // A programmed length of 0 behaves as a one-tick cycle.
  function automatic logic [TICK_W-1:0] last_tick(input logic [TICK_W-1:0] len);
    return (len == '0) ? '0 : len - TICK_W'(1);
  endfunction

  function automatic logic [MUX_W-1:0] next_slot(input logic [MUX_W-1:0] slot);
    return (slot == MUX_W'(MUX_CYCLES - 1)) ? '0 : slot + MUX_W'(1);
  endfunction

  assign unused_rd = ^tmr_readdata[15:1];
  assign len_m1    = last_tick(len_q);
  // >= keeps a tick count left over from a longer earlier cycle from running away
  assign boundary  = (state == ACK) && (tick_cnt >= len_m1);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = CFG;
      CFG:     state_nxt = enable ? VRD : DIS;
      VRD:     state_nxt = enable ? VCHK : DIS;
      VCHK:    state_nxt = (enable && tmr_readdata[0]) ? CLR : DIS;
      CLR:     state_nxt = enable ? WAIT : DIS;
      WAIT: begin
        if (!enable)      state_nxt = DIS;
        else if (tmr_irq) state_nxt = ACK;
      end
      ACK:     state_nxt = SETTLE;
      SETTLE:  state_nxt = enable ? WAIT : DIS;
      DIS:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      tmr_address    <= '0;
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_writedata  <= '0;
      cycle_start    <= 1'b0;
      cycle_count    <= '0;
      mux_slot       <= '0;
      cfg_error      <= 1'b0;
      busy           <= 1'b0;
      tick_cnt       <= '0;
      len_q          <= '0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != IDLE);

      // Bus outputs are registered from the state being entered.
      tmr_chipselect <= 1'b0;
      tmr_write_n    <= 1'b1;
      tmr_address    <= '0;
      tmr_writedata  <= '0;
      case (state_nxt)
        CFG: begin
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 3'd1;
          tmr_writedata  <= 16'h0001;
        end
        VRD, VCHK: begin
          tmr_chipselect <= 1'b1;
          tmr_address    <= 3'd1;
        end
        CLR, ACK: begin
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
        end
        DIS: begin
          tmr_chipselect <= 1'b1;
          tmr_write_n    <= 1'b0;
          tmr_address    <= 3'd1;
        end
        default: ;
      endcase

      cycle_start <= boundary;
      if (state == IDLE && enable)             cfg_error <= 1'b0;
      if (state == VCHK && !tmr_readdata[0])   cfg_error <= 1'b1;
      if (state == CFG)                        len_q     <= cycle_len;

      if (state == ACK) begin
        if (boundary) begin
          tick_cnt    <= '0;
          len_q       <= cycle_len;
          cycle_count <= cycle_count + CNT_W'(1);
          mux_slot    <= next_slot(mux_slot);
        end else begin
          tick_cnt <= tick_cnt + TICK_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mn_cycle_tick_scheduler.sv
// Bench for mn_cycle_tick_scheduler: timer slave model, transaction-level cycle model
// and directed scenarios. cycle_count runs at 12 bits so its wrap is reachable quickly.
module tb_mn_cycle_tick_scheduler;
  localparam int TICK_W     = 8;
  localparam int CNT_W      = 12;
  localparam int MUX_CYCLES = 4;
  localparam int MUX_W      = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic [TICK_W-1:0] cycle_len = '0;
  logic [2:0]        tmr_address;
  logic              tmr_chipselect, tmr_write_n;
  logic [15:0]       tmr_writedata;
  logic [15:0]       tmr_readdata = 16'h0;
  logic              tmr_irq;
  logic              cycle_start;
  logic [CNT_W-1:0]  cycle_count;
  logic [MUX_W-1:0]  mux_slot;
  logic              cfg_error, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mn_cycle_tick_scheduler #(
    .TICK_W(TICK_W), .CNT_W(CNT_W), .MUX_CYCLES(MUX_CYCLES), .MUX_W(MUX_W)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .cycle_len(cycle_len),
    .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect),
    .tmr_write_n(tmr_write_n), .tmr_writedata(tmr_writedata),
    .tmr_readdata(tmr_readdata), .tmr_irq(tmr_irq),
    .cycle_start(cycle_start), .cycle_count(cycle_count), .mux_slot(mux_slot),
    .cfg_error(cfg_error), .busy(busy)
  );

  // Timer slave: control register, timeout flag, registered readdata.
  logic [15:0] t_ctrl = 16'h0;
  logic        t_to = 1'b0;
  logic        tick_req = 1'b0, fast = 1'b0, force_bad = 1'b0;
  logic        wr, rd;
  assign wr      = tmr_chipselect && !tmr_write_n;
  assign rd      = tmr_chipselect && tmr_write_n;
  assign tmr_irq = t_to;

  always @(posedge clk) begin
    if (wr && tmr_address == 3'd1) t_ctrl <= tmr_writedata;
    if (wr && tmr_address == 3'd0) t_to <= 1'b0;
    else if (tick_req || fast)     t_to <= 1'b1;
    tmr_readdata <= rd ? ((tmr_address == 3'd1) ? (force_bad ? 16'h0 : t_ctrl) : {15'b0, t_to})
                       : 16'h0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle model: an acknowledge is a status write that follows an idle bus cycle;
  // every max(len,1) acknowledges close one MN cycle.
  int m_tick = 0, m_len = 0, m_count = 0;
  bit m_bnd = 0, m_prev_idle = 1, m_valid = 0;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid = 1; m_tick = 0; m_len = 0; m_count = 0; m_bnd = 0; m_prev_idle = 1;
    end else begin
      m_bnd = 0;
      if (wr && tmr_address == 3'd1 && tmr_writedata == 16'h0001) m_len = int'(cycle_len);
      if (wr && tmr_address == 3'd0 && m_prev_idle) begin
        if (m_tick + 1 >= ((m_len == 0) ? 1 : m_len)) begin
          m_tick = 0; m_count++; m_bnd = 1; m_len = int'(cycle_len);
        end else begin
          m_tick++;
        end
      end
      m_prev_idle = !tmr_chipselect;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("cmp cycle_start", 32'(cycle_start), 32'(m_bnd));
      chk("cmp cycle_count", 32'(cycle_count), m_count % (1 << CNT_W));
      chk("cmp mux_slot", 32'(mux_slot), m_count % MUX_CYCLES);
      if (!tmr_chipselect)
        chk("cmp idle bus", 32'({tmr_write_n, tmr_address, tmr_writedata}), 32'({1'b1, 19'b0}));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_bus(input string name, input logic cs, input logic wn,
                         input logic [2:0] a, input logic [15:0] d);
    chk(name, 32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}), 32'({cs, wn, a, d}));
  endtask

  task automatic tick(output bit saw);
    @(negedge clk) tick_req = 1'b1;
    @(negedge clk) tick_req = 1'b0;
    saw = 1'b0;
    repeat (6) begin
      if (cycle_start) saw = 1'b1;
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) begin reset_n = 1'b0; enable = 1'b0; end
    @(negedge clk) reset_n = 1'b1;
  endtask

  task automatic chk_zero(input string name);
    chk({name, " bus"}, 32'({tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata}), 32'({1'b0, 1'b1, 19'b0}));
    chk({name, " flags"}, 32'({cycle_start, cfg_error, busy}), 32'h0);
    chk({name, " count"}, 32'({cycle_count, mux_slot}), 32'h0);
  endtask

  initial begin
    bit saw;
    int nwr;
    int n;

    step(2);
    chk_zero("reset");
    reset_n = 1'b1;

    // T1: length 3, exact configuration sequence then ticks
    cycle_len = 8'd3;
    enable = 1'b1;
    step(1); chk_bus("T1 cfg write", 1, 0, 3'd1, 16'h0001);
    step(1); chk_bus("T1 vrd read", 1, 1, 3'd1, 16'h0);
    step(1); chk_bus("T1 vchk read", 1, 1, 3'd1, 16'h0);
    step(1); chk_bus("T1 clr write", 1, 0, 3'd0, 16'h0);
    step(1); chk_bus("T1 wait idle", 0, 1, 3'd0, 16'h0);
    chk("T1 busy", 32'(busy), 32'd1);
    for (int i = 1; i <= 9; i++) begin
      tick(saw);
      chk($sformatf("T1 start tick%0d", i), 32'(saw), 32'((i % 3) == 0));
    end
    chk("T1 count", 32'(cycle_count), 32'd3);
    chk("T1 mux", 32'(mux_slot), 32'd3);

    // T2: length 0 gives a cycle per tick; a later length change takes one cycle to apply
    do_reset();
    cycle_len = 8'd0;
    enable = 1'b1;
    step(5);
    for (int i = 1; i <= 4; i++) begin
      tick(saw);
      chk($sformatf("T2 start tick%0d", i), 32'(saw), 32'd1);
    end
    chk("T2 count", 32'(cycle_count), 32'd4);
    chk("T2 mux wrap", 32'(mux_slot), 32'd0);
    cycle_len = 8'd2;
    tick(saw); chk("T2 len old", 32'(saw), 32'd1);
    tick(saw); chk("T2 len new a", 32'(saw), 32'd0);
    tick(saw); chk("T2 len new b", 32'(saw), 32'd1);

    // T4: enable dropped during the acknowledge cycle
    @(negedge clk) tick_req = 1'b1;
    @(negedge clk) tick_req = 1'b0;
    step(1); chk_bus("T4 ack write", 1, 0, 3'd0, 16'h0);
    enable = 1'b0;
    step(1); chk_bus("T4 settle idle", 0, 1, 3'd0, 16'h0);
    chk("T4 settle busy", 32'(busy), 32'd1);
    step(1); chk_bus("T4 dis write", 1, 0, 3'd1, 16'h0);
    step(1); chk("T4 idle busy", 32'(busy), 32'd0);
    nwr = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) tick_req = 1'b1;
      repeat (6) begin
        @(negedge clk) tick_req = 1'b0;
        if (tmr_chipselect) nwr++;
      end
    end
    chk("T4 irq seen", 32'(tmr_irq), 32'd1);
    chk("T4 no transfers", 32'(nwr), 32'd0);

    // T3: control readback 0
    force_bad = 1'b1;
    do_reset();
    enable = 1'b1;
    step(3); chk_bus("T3 vchk read", 1, 1, 3'd1, 16'h0);
    step(1); chk_bus("T3 dis write", 1, 0, 3'd1, 16'h0);
    chk("T3 cfg_error", 32'(cfg_error), 32'd1);
    enable = 1'b0;
    step(1); chk("T3 idle busy", 32'(busy), 32'd0);
    chk_bus("T3 idle bus", 0, 1, 3'd0, 16'h0);
    chk("T3 cfg_error sticky", 32'(cfg_error), 32'd1);
    force_bad = 1'b0;

    // T5: re-enable clears the error; reset in VCHK and in WAIT
    enable = 1'b1;
    step(1); chk_bus("T5 cfg write", 1, 0, 3'd1, 16'h0001);
    chk("T5 cfg_error cleared", 32'(cfg_error), 32'd0);
    step(2); chk_bus("T5 vchk read", 1, 1, 3'd1, 16'h0);
    reset_n = 1'b0;
    step(1); chk_zero("T5 rst vchk");
    reset_n = 1'b1;
    step(1); chk_bus("T5 recfg write", 1, 0, 3'd1, 16'h0001);
    cycle_len = 8'd1;
    step(4);
    tick(saw); chk("T5 start a", 32'(saw), 32'd1);
    tick(saw); chk("T5 start b", 32'(saw), 32'd1);
    chk("T5 count", 32'(cycle_count), 32'd2);
    reset_n = 1'b0;
    step(1); chk_zero("T5 rst wait");
    reset_n = 1'b1;
    step(1); chk_bus("T5 recfg2 write", 1, 0, 3'd1, 16'h0001);
    step(4);

    // T6: continuous ticks up to and through the counter wrap
    cycle_len = 8'd0;
    fast = 1'b1;
    n = 0;
    while (cycle_count != {CNT_W{1'b1}} && n < 20000) begin step(1); n++; end
    chk("T6 reached max", 32'(cycle_count), 32'({CNT_W{1'b1}}));
    step(1);
    n = 0;
    while (!cycle_start && n < 10) begin step(1); n++; end
    chk("T6 wrap pulse", 32'(cycle_start), 32'd1);
    chk("T6 wrap count", 32'(cycle_count), 32'd0);
    chk("T6 wrap mux", 32'(mux_slot), 32'd0);
    fast = 1'b0;
    enable = 1'b0;
    step(6);
    chk("T6 stopped", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
